// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, fetch state encoding and the HALT opcode.
package cpu_pkg;

    localparam int WORD_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fetch_state_t;

    localparam logic [3:0] HALT_OPCODE = 4'hF;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds pc and the instruction register, and handshakes with instruction memory.
// Define FETCH_HALT_EN to make opcode 4'hF a sticky halt; otherwise halted is tied low.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 16'h0000,
    parameter int                PC_STEP  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch,
    input  logic              writeback,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_target,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] pc,
    output logic              instr_valid,
    output logic              stall,
    output logic              halted
);

    localparam logic [WORD_W-1:0] PC_INC = WORD_W'(PC_STEP);

    fetch_state_t state;
    fetch_state_t nextState;
    logic         capture;
    logic         redirect;
    logic         haltCapture;

    assign capture  = imem_req & imem_ready;
    assign redirect = writeback & branch_taken;

`ifdef FETCH_HALT_EN
    assign haltCapture = capture && (imem_rdata[WORD_W-1:WORD_W-4] == HALT_OPCODE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            halted <= 1'b0;
        end else if (haltCapture) begin
            halted <= 1'b1;
        end
    end
`else
    assign haltCapture = 1'b0;
    assign halted      = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Once a request is issued it is held until memory answers, even if fetch drops.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (fetch && !halted && !imem_ready) nextState = WAIT;
            WAIT: if (imem_ready) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        imem_req  = ((state == IDLE) && fetch && !halted) || (state == WAIT);
        stall     = imem_req && !imem_ready;
        imem_addr = pc;
    end

    // A branch redirect overrides the post-capture increment, but the captured word is kept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
        end else begin
            if (capture) begin
                instr       <= imem_rdata;
                instr_valid <= 1'b1;
                if (!haltCapture) begin
                    pc <= pc + PC_INC;
                end
            end else if ((state == IDLE) && imem_req) begin
                instr_valid <= 1'b0;
            end
            if (redirect) begin
                pc <= branch_target;
                if (!capture) begin
                    instr_valid <= 1'b0;
                end
            end
        end
    end

endmodule
